addsub_pipe: RTL and testbench
==============================

# addsub_pipe

Parametrised, pipelined N-bit adder/subtractor that extends the plain ripple-carry adder with carry-in, subtract modes, status flags, and a valid/ready stream interface. Operands are split into SEG-bit segments, and one segment is resolved per pipeline stage. Carries and the upper operand bits are skewed through registers, so the block sustains one operation per clock at any N. It sits between the register-file read ports and the ALU result mux.

## Interface
- N, default 16: operand/result width; must be a multiple of SEG.
- SEG, default 4: bits resolved per pipeline stage; STAGES = N/SEG, 1 ≤ STAGES.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/op valid this cycle.
- in_ready  output  1  block can accept this cycle.
- a  input  N  operand A (unsigned/two's complement).
- b  input  N  operand B.
- op  input  2  00 ADD a+b; 01 ADC a+b+cin; 10 SUB a+~b+1; 11 SBB a+~b+cin.
- cin  input  1  carry-in for ADC/SBB; ignored otherwise. SBB: cin=1 means no borrow.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  N  result, modulo 2^N.
- c_out  output  1  carry out of bit N-1. SUB/SBB: 1 means no borrow.
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.

## Operation
- **Accept:** an operation is accepted when in_valid && in_ready.
- **Stage 0 (on accept):**
  - b_eff = b inverted for op[1]=1, else b.
  - c0 = 0 for ADD, 1 for SUB, cin for ADC/SBB.
  - Computes segment 0 (bits SEG-1:0) plus its carry.
  - Registers the remaining unresolved a/b_eff segments.
- **Stage k (k = 1..STAGES-1):** adds segment k of a/b_eff plus the registered carry from stage k-1. Resolved low segments travel forward unchanged.
- **Final stage outputs:**
  - sum = concatenation of all resolved segments.
  - c_out = carry out of the top segment.
  - ovf = carry into bit N-1 XOR carry out of bit N-1.
  - zero = (sum == 0).
- **Result register:** all outputs are registered, with no combinational path from inputs to outputs.
- **Stage valids:** each stage carries a valid bit. Bubbles are allowed and are not compressed.
- **Stall rule:**
  - stall = out_valid && !out_ready.
  - When stalled, every stage register (data and valid) holds.
  - in_ready = !stall. This is a global stall, not per-stage skid.
- **Ordering:** results leave in acceptance order. There is no loss and no duplication.
- **Stage 1 (STAGES=1):** the block is a single registered adder stage with the same handshake.

## Timing
- **Reset:**
  - While rst_n=0, all stage valid bits are 0, and out_valid=0.
  - sum, c_out, ovf and zero are 0.
  - in_ready=1 once any stall is cleared (out_valid=0 ⇒ in_ready=1).
- **Reset mid-operation:** asynchronous assertion clears all in-flight operations immediately. Nothing from before reset ever appears after rst_n releases.
- **Latency:** an op accepted at edge t is presented with out_valid=1 after edge t+STAGES-1. In other words, the result register loads on the STAGES-th accepting edge, counting the accept edge as 1, provided no stall occurs in between.
- **Stall cycles:** each stalled cycle adds exactly one cycle of latency to every in-flight operation.
- **Throughput:** one op per cycle when out_ready is held at 1.
- **Handshake:**
  - out_valid and the data stay stable until out_ready=1.
  - Upstream may change a/b/op/cin freely when in_valid=0 or in_ready=0. Values are sampled only on accept.
- **Simultaneous events:** out_ready=1 with out_valid=1 and in_valid=1 in the same cycle means the result retires and the new op is accepted on the same edge (full rate).

## Test plan
All scenarios use N=16, SEG=4, so latency is 4.

- **ADD, carry across segments:** ADD a=0x00FF, b=0x0001, out_ready=1 → sum=0x0100, c_out=0, ovf=0, zero=0, out_valid exactly 4 edges after accept.
- **ADD overflow, ADC wrap:**
  - ADD 0x7FFF+0x0001 → sum=0x8000, ovf=1, c_out=0.
  - ADC 0xFFFF+0x0000 with cin=1 → sum=0x0000, c_out=1, zero=1, ovf=0.
- **SUB and SBB:**
  - SUB 0x0005−0x0005 → sum=0x0000, c_out=1, zero=1.
  - SBB 0x0000−0x0000 with cin=0 → sum=0xFFFF, c_out=0, ovf=0.
- **Stream with backpressure:** 32 random ops back-to-back, out_ready driven by a random 50% pattern → results match the reference model in order. in_ready is low exactly when out_valid && !out_ready, and held outputs are stable while stalled.
- **Reset mid-stream:** accept 3 ops, pull rst_n low asynchronously mid-cycle for 2 cycles, then release → out_valid falls immediately and all outputs read 0. No result appears for 10 cycles after release; a new op then returns correctly 4 cycles after accept.
- **Bubbles:** pattern in_valid = 1,0,1,0 → results emerge with the same 1,0,1,0 spacing, each with latency 4.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined N-bit adder/subtractor: one SEG-bit segment resolved per stage,
// with valid/ready handshake, global stall and registered status flags.
module addsub_pipe #(
    parameter int unsigned N   = 16,
    parameter int unsigned SEG = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf,
    output logic         zero
);

    localparam int unsigned STAGES = N / SEG;

    // Each stage register holds the full-width operands and partial sum so the
    // unresolved upper segments ride along with the resolved lower ones.
    logic [N-1:0] a_q [STAGES];
    logic [N-1:0] b_q [STAGES];
    logic [N-1:0] s_q [STAGES];
    logic         c_q [STAGES];
    logic         v_q [STAGES];
    logic         ovf_q;
    logic         zero_q;

    logic [N-1:0] a_d [STAGES];
    logic [N-1:0] b_d [STAGES];
    logic [N-1:0] s_d [STAGES];
    logic         c_d [STAGES];
    logic         v_d [STAGES];
    logic         ovf_d;
    logic         zero_d;
    logic         stall;

    assign stall     = v_q[STAGES-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign c_out     = c_q[STAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    always_comb begin
        logic [N-1:0] ai;
        logic [N-1:0] bi;
        logic [N-1:0] si;
        logic         ci;
        logic         vi;
        logic [SEG:0] t;
        int unsigned  km1;
        for (int unsigned k = 0; k < STAGES; k++) begin
            km1 = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                ai = a;
                bi = op[1] ? ~b : b;
                unique case (op)
                    2'b00:   ci = 1'b0;
                    2'b10:   ci = 1'b1;
                    default: ci = cin;
                endcase
                si = '0;
                vi = in_valid;
            end else begin
                ai = a_q[km1];
                bi = b_q[km1];
                si = s_q[km1];
                ci = c_q[km1];
                vi = v_q[km1];
            end
            t = {1'b0, ai[k*SEG +: SEG]} + {1'b0, bi[k*SEG +: SEG]} + {{SEG{1'b0}}, ci};
            si[k*SEG +: SEG] = t[SEG-1:0];
            a_d[k] = ai;
            b_d[k] = bi;
            s_d[k] = si;
            c_d[k] = t[SEG];
            v_d[k] = vi;
        end
        // Carry into the MSB is recovered from the MSB's own sum bit.
        ovf_d  = c_d[STAGES-1] ^ (a_d[STAGES-1][N-1] ^ b_d[STAGES-1][N-1] ^ s_d[STAGES-1][N-1]);
        zero_d = (s_d[STAGES-1] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= v_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (N=16, SEG=4): directed cases, random
// backpressured stream, bubbles and mid-stream reset against an arithmetic model.
module tb_addsub_pipe;

    localparam int unsigned STAGES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [1:0]  op = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;
    logic        zero;

    addsub_pipe #(.N(16), .SEG(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] exp;
        int          adv;
    } entry_t;

    entry_t      q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          adv = 0;
    bit          presented = 0;
    bit          use_dir = 0;
    logic [18:0] dir_exp = '0;
    int          n_acc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {c_out, ovf, zero, sum} from plain integer arithmetic.
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic [1:0] o, input logic ci);
        logic [15:0] yy;
        int          c0;
        int unsigned u;
        int          sx;
        int          sy;
        int          s;
        logic        v;
        yy = o[1] ? ~y : y;
        c0 = (o == 2'b00) ? 0 : (o == 2'b10) ? 1 : int'(ci);
        u  = 32'(x) + 32'(yy) + 32'(c0);
        sx = $signed(x);
        sy = $signed(yy);
        s  = sx + sy + c0;
        v  = (s > 32767) || (s < -32768);
        return {u[16], v, (u[15:0] == 16'h0), u[15:0]};
    endfunction

    // One cycle: inputs are already driven; evaluate handshake before the edge.
    task automatic step();
        logic stall;
        #1;
        stall = out_valid && !out_ready;
        check("in_ready", 32'(in_ready), 32'(!stall));
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                if (!presented) begin
                    check("latency", 32'(adv - q[0].adv), STAGES);
                    presented = 1;
                end
                check("result", 32'({c_out, ovf, zero, sum}), 32'(q[0].exp));
                if (out_ready) begin
                    void'(q.pop_front());
                    presented = 0;
                end
            end
        end
        if (in_valid && in_ready) begin
            q.push_back('{exp: use_dir ? dir_exp : model(a, b, op, cin), adv: adv});
            n_acc++;
        end
        if (!stall) adv++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        in_valid = 1'b0;
        for (int i = 0; i < budget && q.size() != 0; i++) step();
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic directed(input logic [15:0] x, input logic [15:0] y, input logic [1:0] o,
                            input logic ci, input logic [18:0] e);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = x; b = y; op = o; cin = ci;
        use_dir = 1; dir_exp = e;
        step();
        use_dir = 0;
        drain(20);
    endtask

    initial begin
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'({c_out, ovf, zero, sum}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        //              a        b        op     cin   {c, ovf, zero, sum}
        directed(16'h00FF, 16'h0001, 2'b00, 1'b0, {3'b000, 16'h0100});
        directed(16'h7FFF, 16'h0001, 2'b00, 1'b0, {3'b010, 16'h8000});
        directed(16'hFFFF, 16'h0000, 2'b01, 1'b1, {3'b101, 16'h0000});
        directed(16'h0005, 16'h0005, 2'b10, 1'b0, {3'b101, 16'h0000});
        directed(16'h0000, 16'h0000, 2'b11, 1'b0, {3'b000, 16'hFFFF});
        directed(16'h8000, 16'h0001, 2'b10, 1'b1, {3'b110, 16'h7FFF});

        // Random stream with 50% backpressure; new operands every cycle.
        n_acc = 0;
        for (int i = 0; i < 400 && n_acc < 32; i++) begin
            in_valid  = 1'b1;
            a         = 16'($urandom);
            b         = 16'($urandom);
            op        = 2'($urandom);
            cin       = 1'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        check("stream_accepts", 32'(n_acc), 32'd32);
        out_ready = 1'b1;
        drain(40);

        // Bubbles: 1,0,1,0 spacing must survive with unchanged latency.
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); cin = 1'($urandom);
            step();
        end
        drain(20);

        // Reset mid-stream while the first result is on the output.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); cin = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'({c_out, ovf, zero, sum}), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        q.delete();
        presented = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        directed(16'h1234, 16'h4321, 2'b00, 1'b0, {3'b000, 16'h5555});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
